// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback
//  Description : Register-file write-side driver. ALU and LSU results arrive
//                over valid/ready and are buffered in one FIFO per source.
//                A round-robin arbiter pops at most one head per cycle into a
//                registered wen/waddr/wdata port. Results for x0 are popped
//                but never raise wen. query_hit reports whether a register
//                still has a write in flight, for stall logic.
//  Ports       : clk, reset (async, active-high)
//                alu_valid/alu_ready/alu_rd/alu_data : ALU result input
//                lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU result input
//                wen/waddr/wdata                     : RF write port (registered)
//                query_addr/query_hit                : pending-write lookup
//                pending                             : buffered + issuing count
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  rf_writeback_fifo : per-source result buffer with associative rd lookup.
//  Ports: push/push_rd/push_data (push ignored when full), pop (caller only
//  pops when not empty), head_rd/head_data, full/empty/count, query_match.
// ----------------------------------------------------------------------------
module rf_writeback_fifo #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_rd,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] query_addr,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count,
   output logic [ADDR_WIDTH-1:0] head_rd,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  query_match
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] r_rd   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_vld;
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_push;
   logic                  w_pop;

   assign full      = (r_count == CNT_W'(FIFO_DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head_rd   = r_rd[r_rptr];
   assign head_data = r_data[r_rptr];

   // Full blocks the push even if a pop frees a slot this cycle.
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         // wptr == rptr only when empty or full, so a push and a pop never
         // touch the same valid bit in one cycle.
         if (w_push) begin
            r_wptr         <= r_wptr + PTR_W'(1);
            r_vld[r_wptr]  <= 1'b1;
         end
         if (w_pop) begin
            r_rptr         <= r_rptr + PTR_W'(1);
            r_vld[r_rptr]  <= 1'b0;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Payload storage needs no reset: the valid bits qualify every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd[r_wptr]   <= push_rd;
         r_data[r_wptr] <= push_data;
      end
   end

   always_comb begin
      query_match = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (r_vld[i] && (r_rd[i] == query_addr)) begin
            query_match = 1'b1;
         end
      end
   end
endmodule

// ----------------------------------------------------------------------------
//  rf_writeback : top level.
// ----------------------------------------------------------------------------
module rf_writeback #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                alu_valid,
   output logic                                alu_ready,
   input  logic [ADDR_WIDTH-1:0]               alu_rd,
   input  logic [DATA_WIDTH-1:0]               alu_data,
   input  logic                                lsu_valid,
   output logic                                lsu_ready,
   input  logic [ADDR_WIDTH-1:0]               lsu_rd,
   input  logic [DATA_WIDTH-1:0]               lsu_data,
   output logic                                wen,
   output logic [ADDR_WIDTH-1:0]               waddr,
   output logic [DATA_WIDTH-1:0]               wdata,
   input  logic [ADDR_WIDTH-1:0]               query_addr,
   output logic                                query_hit,
   output logic [$clog2(2*FIFO_DEPTH+2)-1:0]   pending
);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PEND_W = $clog2(2*FIFO_DEPTH + 2);

   logic                  w_alu_full, w_alu_empty, w_alu_match;
   logic                  w_lsu_full, w_lsu_empty, w_lsu_match;
   logic [CNT_W-1:0]      w_alu_cnt, w_lsu_cnt;
   logic [ADDR_WIDTH-1:0] w_alu_head_rd, w_lsu_head_rd, w_sel_rd;
   logic [DATA_WIDTH-1:0] w_alu_head_data, w_lsu_head_data, w_sel_data;
   logic                  w_pop_alu, w_pop_lsu, w_any_pop;
   logic                  w_both;

   // 1 = ALU wins the next contended cycle; reset favours the LSU.
   logic                  r_rr_alu;
   logic                  r_wen;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0] r_wdata;

   rf_writeback_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_alu_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (alu_valid),
      .push_rd     (alu_rd),
      .push_data   (alu_data),
      .pop         (w_pop_alu),
      .query_addr  (query_addr),
      .full        (w_alu_full),
      .empty       (w_alu_empty),
      .count       (w_alu_cnt),
      .head_rd     (w_alu_head_rd),
      .head_data   (w_alu_head_data),
      .query_match (w_alu_match)
   );

   rf_writeback_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_lsu_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (lsu_valid),
      .push_rd     (lsu_rd),
      .push_data   (lsu_data),
      .pop         (w_pop_lsu),
      .query_addr  (query_addr),
      .full        (w_lsu_full),
      .empty       (w_lsu_empty),
      .count       (w_lsu_cnt),
      .head_rd     (w_lsu_head_rd),
      .head_data   (w_lsu_head_data),
      .query_match (w_lsu_match)
   );

   assign alu_ready = !w_alu_full;
   assign lsu_ready = !w_lsu_full;

   // Arbitration: a lone non-empty FIFO always wins; rr only decides ties.
   assign w_both     = !w_alu_empty && !w_lsu_empty;
   assign w_pop_alu  = !w_alu_empty && (w_lsu_empty || r_rr_alu);
   assign w_pop_lsu  = !w_lsu_empty && (w_alu_empty || !r_rr_alu);
   assign w_any_pop  = w_pop_alu || w_pop_lsu;
   assign w_sel_rd   = w_pop_alu ? w_alu_head_rd   : w_lsu_head_rd;
   assign w_sel_data = w_pop_alu ? w_alu_head_data : w_lsu_head_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_alu <= 1'b0;
         r_wen    <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
      end else begin
         if (w_both) begin
            r_rr_alu <= !r_rr_alu;
         end
         // x0 results are consumed silently; address/data hold when idle.
         if (w_any_pop && (w_sel_rd != '0)) begin
            r_wen   <= 1'b1;
            r_waddr <= w_sel_rd;
            r_wdata <= w_sel_data;
         end else begin
            r_wen   <= 1'b0;
         end
      end
   end

   assign wen   = r_wen;
   assign waddr = r_waddr;
   assign wdata = r_wdata;

   assign query_hit = (query_addr != '0) &&
                      (w_alu_match || w_lsu_match || (r_wen && (r_waddr == query_addr)));

   assign pending = PEND_W'(w_alu_cnt) + PEND_W'(w_lsu_cnt) + PEND_W'(r_wen);
endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_writeback
//  Description : Directed self-checking bench for rf_writeback with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_writeback;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int D  = 2;
   localparam int PW = $clog2(2*D+2);

   logic          clk = 1'b0;
   logic          reset;
   logic          alu_valid, lsu_valid;
   logic          alu_ready, lsu_ready;
   logic [AW-1:0] alu_rd, lsu_rd, query_addr, waddr;
   logic [DW-1:0] alu_data, lsu_data, wdata;
   logic          wen, query_hit;
   logic [PW-1:0] pending;

   int tests_run    = 0;
   int tests_failed = 0;

   rf_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .wen        (wen),
      .waddr      (waddr),
      .wdata      (wdata),
      .query_addr (query_addr),
      .query_hit  (query_hit),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 ns so outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          cyc, lsu_n, alu_acc, alu_w, wen_seen;
   logic        ra, rl;
   logic [AW-1:0] seq_rd[$];
   logic [DW-1:0] seq_dat[$];

   initial begin
      reset = 1'b1; alu_valid = 0; lsu_valid = 0;
      alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0; query_addr = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_wen",     wen, 0);
      check("rst_waddr",   waddr, 0);
      check("rst_wdata",   wdata, 0);
      check("rst_pending", pending, 0);
      check("rst_alu_rdy", alu_ready, 1);
      check("rst_lsu_rdy", lsu_ready, 1);

      // 1: single ALU write
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 0;
      check("t1_e0_wen",     wen, 0);
      check("t1_e0_pending", pending, 1);
      tick();
      check("t1_e1_wen",     wen, 1);
      check("t1_e1_waddr",   waddr, 5);
      check("t1_e1_wdata",   wdata, 32'hDEADBEEF);
      check("t1_e1_pending", pending, 1);
      tick();
      check("t1_e2_wen",     wen, 0);
      check("t1_e2_pending", pending, 0);

      // 2: simultaneous pushes, rr starts LSU-first then alternates
      alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
      lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
      tick();
      alu_valid = 0; lsu_valid = 0;
      check("t2a_pending", pending, 2);
      tick();
      check("t2a_w1_wen",   wen, 1);
      check("t2a_w1_waddr", waddr, 4);
      check("t2a_w1_wdata", wdata, 32'h22);
      check("t2a_w1_pend",  pending, 2);
      tick();
      check("t2a_w2_waddr", waddr, 3);
      check("t2a_w2_wdata", wdata, 32'h11);
      tick();
      check("t2a_idle_wen", wen, 0);
      alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
      lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
      tick();
      alu_valid = 0; lsu_valid = 0;
      tick();
      check("t2b_w1_waddr", waddr, 3);
      check("t2b_w1_wdata", wdata, 32'h33);
      tick();
      check("t2b_w2_waddr", waddr, 4);
      check("t2b_w2_wdata", wdata, 32'h44);
      tick();

      // 3: write to x0 is consumed silently; waddr holds previous value
      query_addr = 0;
      alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
      #1;
      check("t3_qhit_pre", query_hit, 0);
      tick();
      alu_valid = 0;
      check("t3_e0_pend", pending, 1);
      check("t3_e0_qhit", query_hit, 0);
      tick();
      check("t3_e1_wen",   wen, 0);
      check("t3_e1_pend",  pending, 0);
      check("t3_e1_waddr", waddr, 4);
      check("t3_e1_qhit",  query_hit, 0);
      check("t3_alu_rdy",  alu_ready, 1);

      // 4: LSU stream of 4 while ALU floods rd=9
      lsu_valid = 1; lsu_rd = 1; lsu_data = 32'h101;
      alu_valid = 1; alu_rd = 9; alu_data = 32'hA00;
      cyc = 0; lsu_n = 0; alu_acc = 0; alu_w = 0;
      while (lsu_n < 4 && cyc < 40) begin
         ra = alu_ready; rl = lsu_ready;
         tick(); cyc++;
         if (alu_valid && ra) begin alu_acc++; alu_data = alu_data + 1; end
         if (rl) begin
            lsu_n++;
            lsu_rd = AW'(lsu_n + 1);
            lsu_data = 32'h100 + DW'(lsu_n + 1);
         end
         if (wen) begin
            if (waddr == 9) alu_w++;
            else begin seq_rd.push_back(waddr); seq_dat.push_back(wdata); end
         end
         if (cyc == 3) begin
            check("t4_lsu_rdy_full", lsu_ready, 0);
            check("t4_pending",      pending, 4);
         end
         if (lsu_n == 4) begin lsu_valid = 0; alu_valid = 0; end
      end
      check("t4_lsu_all_acc", lsu_n, 4);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (wen) begin
            if (waddr == 9) alu_w++;
            else begin seq_rd.push_back(waddr); seq_dat.push_back(wdata); end
         end
      end
      check("t4_alu_writes", alu_w, alu_acc);
      check("t4_lsu_count",  seq_rd.size(), 4);
      for (int i = 0; i < 4 && i < seq_rd.size(); i++) begin
         check($sformatf("t4_lsu_rd%0d", i),  seq_rd[i],  i + 1);
         check($sformatf("t4_lsu_dat%0d", i), seq_dat[i], 32'h101 + i);
      end
      check("t4_drained", pending, 0);

      // 5: query_hit tracks pending rd=7 through the output register
      query_addr = 7;
      #1;
      check("t5_qhit_pre", query_hit, 0);
      lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
      tick();
      lsu_valid = 0;
      check("t5_e0_qhit", query_hit, 1);
      tick();
      check("t5_e1_wen",   wen, 1);
      check("t5_e1_waddr", waddr, 7);
      check("t5_e1_qhit",  query_hit, 1);
      tick();
      check("t5_e2_wen",   wen, 0);
      check("t5_e2_qhit",  query_hit, 0);

      // 6: asynchronous reset mid-stream flushes everything
      query_addr = 10;
      alu_valid = 1; alu_rd = 10; alu_data = 32'hAAAA;
      lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hBBBB;
      tick(); tick(); tick();
      alu_valid = 0; lsu_valid = 0;
      check("t6_pre_wen",  wen, 1);
      check("t6_pre_qhit", query_hit, 1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_wen",   wen, 0);
      check("t6_rst_pend",  pending, 0);
      check("t6_rst_waddr", waddr, 0);
      check("t6_rst_qhit",  query_hit, 0);
      tick();
      reset = 1'b0;
      #1;
      check("t6_alu_rdy", alu_ready, 1);
      check("t6_lsu_rdy", lsu_ready, 1);
      wen_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wen) wen_seen++;
      end
      check("t6_no_write", wen_seen, 0);
      check("t6_pend_end", pending, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
